// File: rtl/pi1_arb_pkg.sv
// Shared PI1 definitions: op encodings, arbiter FSM states and a constant clog2 helper.
package pi1_arb_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    typedef enum logic {
        ST_ARB,
        ST_WAIT
    } arbState_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pi1_arb_if.sv
// Bundle of the per-master PI1 request/response buses and the single downstream slave bus.
interface pi1_arb_if #(
    parameter int MASTERCOUNT = 2,
    parameter int ARCHBITSZ   = 16
);
    import pi1_arb_pkg::*;

    localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8);
    localparam int SELBITSZ  = ARCHBITSZ / 8;

    logic [2*MASTERCOUNT-1:0]         m_op_i;
    logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i;
    logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i;
    logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i;
    logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_o;
    logic [MASTERCOUNT-1:0]           m_rdy_o;

    logic [1:0]           s_op_o;
    logic [ADDRBITSZ-1:0] s_addr_o;
    logic [ARCHBITSZ-1:0] s_data_o;
    logic [SELBITSZ-1:0]  s_sel_o;
    logic [ARCHBITSZ-1:0] s_data_i;
    logic                 s_rdy_i;

    // The arbiter sits as the slave of the master buses and drives the slave bus.
    modport slave (
        input  m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i, s_rdy_i,
        output m_data_o, m_rdy_o, s_op_o, s_addr_o, s_data_o, s_sel_o
    );

    modport master (
        output m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i, s_rdy_i,
        input  m_data_o, m_rdy_o, s_op_o, s_addr_o, s_data_o, s_sel_o
    );

endinterface

// File: rtl/pi1_arb_sel.sv
// Combinational grant selection: round-robin after last_grant by default,
// lowest-index-first when PI1_ARB_FIXEDPRIO_EN is defined.
module pi1_arb_sel
    import pi1_arb_pkg::*;
#(
    parameter int MASTERCOUNT = 2
) (
    input  logic [MASTERCOUNT-1:0]        pending_i,
    input  logic [clog2(MASTERCOUNT)-1:0] last_grant_i,
    output logic [clog2(MASTERCOUNT)-1:0] grant_o,
    output logic                          valid_o
);
    localparam int GW = clog2(MASTERCOUNT);

`ifdef PI1_ARB_FIXEDPRIO_EN
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int i = MASTERCOUNT - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                grant_o = GW'(i);
                valid_o = 1'b1;
            end
        end
    end
`else
    // Walk offsets from farthest to nearest so the nearest pending master after last_grant wins.
    always_comb begin
        int idx;
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int k = MASTERCOUNT; k >= 1; k--) begin
            idx = int'(last_grant_i) + k;
            if (idx >= MASTERCOUNT) begin
                idx = idx - MASTERCOUNT;
            end
            if (pending_i[idx]) begin
                grant_o = GW'(idx);
                valid_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/pi1_arb.sv
// PI1 arbiter: buffers one request per master and issues them one at a time to a single slave.
module pi1_arb
    import pi1_arb_pkg::*;
#(
    parameter int MASTERCOUNT = 2,
    parameter int ARCHBITSZ   = 16
) (
    input logic      clk_i,
    input logic      rst_i,
    pi1_arb_if.slave bus
);
    localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8);
    localparam int SELBITSZ  = ARCHBITSZ / 8;
    localparam int GW        = clog2(MASTERCOUNT);

    arbState_e              state_q, state_d;
    logic [MASTERCOUNT-1:0] pending_q;
    logic [1:0]             opBuf_q   [MASTERCOUNT];
    logic [ADDRBITSZ-1:0]   addrBuf_q [MASTERCOUNT];
    logic [ARCHBITSZ-1:0]   dataBuf_q [MASTERCOUNT];
    logic [SELBITSZ-1:0]    selBuf_q  [MASTERCOUNT];
    logic [ARCHBITSZ-1:0]   mData_q   [MASTERCOUNT];
    logic [GW-1:0]          grant_q, lastGrant_q;
    logic [ADDRBITSZ-1:0]   sAddr_q;
    logic [ARCHBITSZ-1:0]   sData_q;
    logic [SELBITSZ-1:0]    sSel_q;

    logic [GW-1:0]          selGrant;
    logic                   selValid;
    logic                   issue;
    logic                   complete;

    pi1_arb_sel #(
        .MASTERCOUNT (MASTERCOUNT)
    ) u_sel (
        .pending_i    (pending_q),
        .last_grant_i (lastGrant_q),
        .grant_o      (selGrant),
        .valid_o      (selValid)
    );

    // The issue cycle drives the winner's buffer straight through; otherwise the last grant is held.
    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        complete     = 1'b0;
        bus.s_op_o   = PINOOP;
        bus.s_addr_o = sAddr_q;
        bus.s_data_o = sData_q;
        bus.s_sel_o  = sSel_q;
        case (state_q)
            ST_ARB: begin
                if (selValid && bus.s_rdy_i) begin
                    issue        = 1'b1;
                    bus.s_op_o   = opBuf_q[selGrant];
                    bus.s_addr_o = addrBuf_q[selGrant];
                    bus.s_data_o = dataBuf_q[selGrant];
                    bus.s_sel_o  = selBuf_q[selGrant];
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.s_rdy_i) begin
                    complete = 1'b1;
                    state_d  = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_ARB;
            pending_q   <= '0;
            grant_q     <= '0;
            lastGrant_q <= GW'(MASTERCOUNT - 1);
            sAddr_q     <= '0;
            sData_q     <= '0;
            sSel_q      <= '0;
            for (int i = 0; i < MASTERCOUNT; i++) begin
                opBuf_q[i]   <= PINOOP;
                addrBuf_q[i] <= '0;
                dataBuf_q[i] <= '0;
                selBuf_q[i]  <= '0;
                mData_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            if (issue) begin
                grant_q     <= selGrant;
                lastGrant_q <= selGrant;
                sAddr_q     <= addrBuf_q[selGrant];
                sData_q     <= dataBuf_q[selGrant];
                sSel_q      <= selBuf_q[selGrant];
            end
            // A completing master still reads as busy this edge, so it cannot be re-accepted until the next.
            for (int i = 0; i < MASTERCOUNT; i++) begin
                if (complete && grant_q == GW'(i)) begin
                    pending_q[i] <= 1'b0;
                    if (opBuf_q[i] == PIRDOP || opBuf_q[i] == PIRWOP) begin
                        mData_q[i] <= bus.s_data_i;
                    end
                end
                if (!pending_q[i] && bus.m_op_i[2*i +: 2] != PINOOP) begin
                    pending_q[i] <= 1'b1;
                    opBuf_q[i]   <= bus.m_op_i[2*i +: 2];
                    addrBuf_q[i] <= bus.m_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
                    dataBuf_q[i] <= bus.m_data_i[ARCHBITSZ*i +: ARCHBITSZ];
                    selBuf_q[i]  <= bus.m_sel_i[SELBITSZ*i +: SELBITSZ];
                end
            end
        end
    end

    always_comb begin
        bus.m_rdy_o  = ~pending_q;
        bus.m_data_o = '0;
        for (int i = 0; i < MASTERCOUNT; i++) begin
            bus.m_data_o[ARCHBITSZ*i +: ARCHBITSZ] = mData_q[i];
        end
    end

endmodule

// File: tb/tb_pi1_arb.sv
// Scoreboard bench for pi1_arb (two masters, 16-bit data, round-robin build).
module tb_pi1_arb;
    import pi1_arb_pkg::*;

    localparam int MC  = 2;
    localparam int AW  = 16;
    localparam int ADW = 15;
    localparam int SW  = 2;

    typedef struct packed {
        logic [1:0]     op;
        logic [ADW-1:0] addr;
        logic [AW-1:0]  data;
        logic [SW-1:0]  sel;
    } issue_t;

    typedef struct {
        int            m;
        logic [AW-1:0] data;
    } done_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   issueCount;
    logic [MC-1:0] prevRdy;
    issue_t expIssue[$];
    done_t  expDone[$];

    pi1_arb_if #(.MASTERCOUNT(MC), .ARCHBITSZ(AW)) bus ();

    pi1_arb #(
        .MASTERCOUNT (MC),
        .ARCHBITSZ   (AW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int m, input logic [1:0] op, input logic [ADW-1:0] addr,
                                 input logic [AW-1:0] data, input logic [SW-1:0] sel);
        bus.m_op_i[2*m +: 2]       = op;
        bus.m_addr_i[ADW*m +: ADW] = addr;
        bus.m_data_i[AW*m +: AW]   = data;
        bus.m_sel_i[SW*m +: SW]    = sel;
    endtask

    task automatic expectIssue(input logic [1:0] op, input logic [ADW-1:0] addr,
                               input logic [AW-1:0] data, input logic [SW-1:0] sel);
        issue_t e;
        e.op = op; e.addr = addr; e.data = data; e.sel = sel;
        expIssue.push_back(e);
    endtask

    task automatic expectDone(input int m, input logic [AW-1:0] data);
        done_t d;
        d.m = m; d.data = data;
        expDone.push_back(d);
    endtask

    // Monitor: every slave issue and every master ready-rise is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prevRdy = '1;
        end else begin
            if (bus.s_op_o != PINOOP) begin
                issueCount++;
                if (expIssue.size() == 0) begin
                    checkOutput("unexpected_issue", 64'({bus.s_op_o, bus.s_addr_o}), 64'(0));
                end else begin
                    issue_t e;
                    e = expIssue.pop_front();
                    checkOutput("slave_issue",
                                64'({bus.s_op_o, bus.s_addr_o, bus.s_data_o, bus.s_sel_o}), 64'(e));
                end
            end
            for (int i = 0; i < MC; i++) begin
                if (bus.m_rdy_o[i] && !prevRdy[i]) begin
                    if (expDone.size() == 0) begin
                        checkOutput("unexpected_done", 64'(i), 64'(99));
                    end else begin
                        done_t d;
                        d = expDone.pop_front();
                        checkOutput("done_master", 64'(i), 64'(d.m));
                        checkOutput("done_data", 64'(bus.m_data_o[AW*i +: AW]), 64'(d.data));
                    end
                end
            end
            prevRdy = bus.m_rdy_o;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int cnt[MC];
        int startIssues;
        checks = 0; failures = 0; issueCount = 0; prevRdy = '1;
        rst = 1'b1;
        bus.m_op_i = '0; bus.m_addr_i = '0; bus.m_data_i = '0; bus.m_sel_i = '0;
        bus.s_data_i = '0; bus.s_rdy_i = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset_rdy", 64'(bus.m_rdy_o), 64'(2'b11));
        checkOutput("reset_slave", 64'({bus.s_op_o, bus.s_addr_o, bus.s_data_o, bus.s_sel_o}), 64'(0));
        checkOutput("reset_mdata", 64'(bus.m_data_o), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Simultaneous writes straight after reset: master0 first, then master1.
        startIssues = issueCount;
        expectIssue(PIWROP, 15'h0A, 16'h1111, 2'b01);
        expectIssue(PIWROP, 15'h0B, 16'h2222, 2'b10);
        expectDone(0, 16'h0000);
        expectDone(1, 16'h0000);
        @(negedge clk);
        applyStimulus(0, PIWROP, 15'h0A, 16'h1111, 2'b01);
        applyStimulus(1, PIWROP, 15'h0B, 16'h2222, 2'b10);
        @(posedge clk); #1;
        applyStimulus(0, PINOOP, '0, '0, '0);
        applyStimulus(1, PINOOP, '0, '0, '0);
        repeat (8) @(negedge clk);
        checkOutput("dual_wr_issue_count", 64'(issueCount - startIssues), 64'(2));

        // Single read with a zero-wait slave, checked cycle by cycle.
        bus.s_data_i = 16'hBEEF;
        expectIssue(PIRDOP, 15'h10, 16'h0000, 2'b11);
        expectDone(0, 16'hBEEF);
        @(negedge clk);
        applyStimulus(0, PIRDOP, 15'h10, 16'h0000, 2'b11);
        @(posedge clk); #1;
        applyStimulus(0, PINOOP, '0, '0, '0);
        @(negedge clk);
        checkOutput("rd_cycle1_op", 64'(bus.s_op_o), 64'(PIRDOP));
        checkOutput("rd_cycle1_rdy", 64'(bus.m_rdy_o[0]), 64'(0));
        @(negedge clk);
        checkOutput("rd_cycle2", 64'({bus.s_op_o, bus.m_rdy_o[0]}), 64'({PINOOP, 1'b0}));
        @(negedge clk);
        checkOutput("rd_cycle3_rdy", 64'(bus.m_rdy_o[0]), 64'(1));
        checkOutput("rd_cycle3_data", 64'(bus.m_data_o[15:0]), 64'(16'hBEEF));

        // A write completion leaves the previous read data in place.
        bus.s_data_i = 16'h5A5A;
        expectIssue(PIWROP, 15'h20, 16'h3333, 2'b11);
        expectDone(0, 16'hBEEF);
        @(negedge clk);
        applyStimulus(0, PIWROP, 15'h20, 16'h3333, 2'b11);
        @(posedge clk); #1;
        applyStimulus(0, PINOOP, '0, '0, '0);
        repeat (5) @(negedge clk);
        checkOutput("wr_keeps_data", 64'(bus.m_data_o[15:0]), 64'(16'hBEEF));

        // Both masters read after master0's grant: master1 goes first and the slave stalls it.
        bus.s_data_i = 16'h1234;
        expectIssue(PIRDOP, 15'h30, 16'h0000, 2'b11);
        expectDone(1, 16'h1234);
        expectIssue(PIRDOP, 15'h31, 16'h0000, 2'b11);
        expectDone(0, 16'h1234);
        @(negedge clk);
        applyStimulus(0, PIRDOP, 15'h31, 16'h0000, 2'b11);
        applyStimulus(1, PIRDOP, 15'h30, 16'h0000, 2'b11);
        @(posedge clk); #1;
        applyStimulus(0, PINOOP, '0, '0, '0);
        applyStimulus(1, PINOOP, '0, '0, '0);
        @(posedge clk); #1 bus.s_rdy_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_hold",
                        64'({bus.s_op_o, bus.s_addr_o, bus.s_data_o, bus.s_sel_o, bus.m_rdy_o}),
                        64'({PINOOP, 15'h30, 16'h0000, 2'b11, 2'b00}));
        end
        @(posedge clk); #1 bus.s_rdy_i = 1'b1;
        @(negedge clk);
        checkOutput("stall_still_busy", 64'(bus.m_rdy_o), 64'(2'b00));
        @(negedge clk);
        checkOutput("stall_release_rdy", 64'(bus.m_rdy_o[1]), 64'(1));
        checkOutput("stall_release_data", 64'(bus.m_data_o[31:16]), 64'(16'h1234));
        repeat (6) @(negedge clk);

        // Continuous requests from both masters: grants alternate starting with master1.
        bus.s_data_i = 16'h5555;
        for (int k = 0; k < 4; k++) begin
            expectIssue(PIRDOP, 15'(15'h50 + k), 16'h0000, 2'b11);
            expectDone(1, 16'h5555);
            expectIssue(PIRDOP, 15'(15'h40 + k), 16'h0000, 2'b11);
            expectDone(0, 16'h5555);
        end
        cnt[0] = 0; cnt[1] = 0;
        repeat (40) begin
            @(negedge clk);
            for (int i = 0; i < MC; i++) begin
                if (bus.m_rdy_o[i] && cnt[i] < 4) begin
                    applyStimulus(i, PIRDOP, 15'((i == 0 ? 'h40 : 'h50) + cnt[i]), 16'h0000, 2'b11);
                    cnt[i]++;
                end else begin
                    applyStimulus(i, PINOOP, '0, '0, '0);
                end
            end
        end

        // Reset in the middle of a stalled read abandons it.
        bus.s_data_i = 16'h9999;
        expectIssue(PIRDOP, 15'h60, 16'h0000, 2'b11);
        @(negedge clk);
        applyStimulus(0, PIRDOP, 15'h60, 16'h0000, 2'b11);
        @(posedge clk); #1;
        applyStimulus(0, PINOOP, '0, '0, '0);
        @(posedge clk); #1 bus.s_rdy_i = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        checkOutput("midwait_reset_rdy", 64'(bus.m_rdy_o), 64'(2'b11));
        checkOutput("midwait_reset_slave",
                    64'({bus.s_op_o, bus.s_addr_o, bus.s_data_o, bus.s_sel_o}), 64'(0));
        checkOutput("midwait_reset_mdata", 64'(bus.m_data_o), 64'(0));
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        bus.s_rdy_i  = 1'b1;
        bus.s_data_i = 16'h0F0F;
        expectIssue(PIRDOP, 15'h70, 16'h0000, 2'b11);
        expectDone(1, 16'h0F0F);
        @(negedge clk);
        applyStimulus(1, PIRDOP, 15'h70, 16'h0000, 2'b11);
        @(posedge clk); #1;
        applyStimulus(1, PINOOP, '0, '0, '0);
        repeat (6) @(negedge clk);
        checkOutput("post_reset_mdata", 64'(bus.m_data_o), 64'({16'h0F0F, 16'h0000}));

        checkOutput("issue_queue_drained", 64'(expIssue.size()), 64'(0));
        checkOutput("done_queue_drained", 64'(expDone.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
